mul_share_ctrl: RTL and testbench

Time-shares one combinational `i8bit_mul` 8×8 unsigned multiplier among up to NREQ requesters. Each requester presents two 8-bit operands on a valid/ready handshake. A round-robin arbiter grants one request at a time, and the block registers operands and product. The 16-bit product returns to the owning requester on its own valid/ready response channel. The block sits between the pad-level top wrapper's operand sources and the shared multiplier, so several on-chip clients can use one multiplier array.

---
 rtl/mul_share_pkg.sv | 15 +
 rtl/i8bit_mul.sv | 13 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/mul_share_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing controller.
// Holds the controller state encoding and the operand/product widths used by
// the arbiter-fronted datapath.
package mul_share_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/i8bit_mul.sv
// Combinational 8x8 unsigned multiplier shared by all requesters.
// Ports:
//   a, b : 8-bit unsigned operands
//   p    : full 16-bit product
module i8bit_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = 16'(a) * 16'(b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     : request vector, one bit per requester
//   ptr     : index of the highest-priority requester for this decision
//   gnt     : one-hot grant (all zero when nothing is requesting)
//   gnt_idx : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  // One extra bit so ptr + k never overflows before the wrap subtraction.
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic          found_s;
  logic [PW:0]   sum_s;
  logic [PW-1:0] cand_s;

  // Walk candidates upward from ptr with wrap; first requesting one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr} + (PW+1)'(k);
      if (sum_s >= NREQ_W) begin
        cand_s = PW'(sum_s - NREQ_W);
      end else begin
        cand_s = PW'(sum_s);
      end
      if (!found_s && req[cand_s]) begin
        found_s      = 1'b1;
        gnt[cand_s]  = 1'b1;
        gnt_idx      = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Time-shares one 8x8 multiplier among NREQ requesters.
// A round-robin arbiter picks one operand request at a time; operands are
// registered, the product is registered one cycle later and is then held on
// the owner's response channel until accepted.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept (one-hot or zero, combinational)
//   req_a/b    : packed operands, requester i on bits [8i+7:8i]
//   rsp_valid  : per-requester response valid (one-hot or zero)
//   rsp_ready  : per-requester response accept (only the owner's bit matters)
//   rsp_prod   : 16-bit product, meaningful while any rsp_valid bit is set
//   busy       : high whenever an operation is in flight
//   op_count   : completed responses, wraps modulo 2^CNT_W
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [PROD_W-1:0]    rsp_prod,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int PW = $clog2(NREQ);

  state_e            state_r;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     own_r;
  logic [OP_W-1:0]   op_a_r;
  logic [OP_W-1:0]   op_b_r;
  logic [PROD_W-1:0] prod_q_r;
  logic [CNT_W-1:0]  op_count_r;
  logic [NREQ-1:0]   rsp_valid_r;
  logic              busy_r;

  logic [NREQ-1:0]   gnt_s;
  logic [PW-1:0]     gnt_idx_s;
  logic [PW-1:0]     ptr_nxt_s;
  logic [OP_W-1:0]   sel_a_s;
  logic [OP_W-1:0]   sel_b_s;
  logic [PROD_W-1:0] mul_p_s;

  function automatic logic [NREQ-1:0] idx_onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  i8bit_mul u_mul (
    .a (op_a_r),
    .b (op_b_r),
    .p (mul_p_s)
  );

  // Route the granted requester's operands toward the operand registers.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_s == PW'(i)) begin
        sel_a_s = req_a[i*OP_W +: OP_W];
        sel_b_s = req_b[i*OP_W +: OP_W];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // Priority moves to the requester just after the one being granted.
  always_comb begin
    if (gnt_idx_s == PW'(NREQ-1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + PW'(1);
    end
  end

  // Accept is offered only while idle and never while reset is asserted.
  always_comb begin
    if (rst_n && (state_r == ST_IDLE)) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  // Controller FSM with operand, product, owner and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      own_r       <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      prod_q_r    <= '0;
      op_count_r  <= '0;
      rsp_valid_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            op_a_r  <= sel_a_s;
            op_b_r  <= sel_b_s;
            own_r   <= gnt_idx_s;
            ptr_r   <= ptr_nxt_s;
            busy_r  <= 1'b1;
            state_r <= ST_MUL;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          prod_q_r    <= mul_p_s;
          rsp_valid_r <= idx_onehot(own_r);
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's ready bit can complete the transfer.
          if (rsp_ready[own_r]) begin
            rsp_valid_r <= '0;
            op_count_r  <= op_count_r + CNT_W'(1);
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_prod  = prod_q_r;
  assign busy      = busy_r;
  assign op_count  = op_count_r;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl (NREQ=4, CNT_W=4).
// A transaction-level model predicts the outputs every cycle; directed
// sections pin hand-computed values, then a randomized phase runs.
module tb_mul_share_ctrl;

  localparam int NREQ  = 4;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [15:0]       rsp_prod;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  int total = 0;
  int bad   = 0;

  // Model: at most one operation in flight, described by owner, product and age.
  bit          m_have  = 1'b0;
  int          m_own   = 0;
  int          m_age   = 0;
  int          m_ptr   = 0;
  int          m_count = 0;
  logic [15:0] m_prod  = 16'h0000;

  logic [NREQ-1:0] acc_v;

  mul_share_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model with the
  // inputs that will be sampled at the coming rising edge.
  initial begin
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_rv;
    int g;
    forever begin
      @(negedge clk);
      e_rdy = '0;
      g = -1;
      if (rst_n === 1'b1 && !m_have) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
      if (g >= 0) e_rdy[g] = 1'b1;
      e_rv = '0;
      if (m_have && m_age >= 1) e_rv[m_own] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(e_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      check("busy", 32'(busy), 32'(m_have));
      check("op_count", 32'(op_count), 32'(m_count % 16));
      if (e_rv != '0) check("rsp_prod", 32'(rsp_prod), 32'(m_prod));
      if (rst_n !== 1'b1) begin
        m_have = 1'b0; m_ptr = 0; m_count = 0; m_age = 0; m_own = 0;
      end else if (!m_have) begin
        if (g >= 0) begin
          m_have = 1'b1;
          m_own  = g;
          m_age  = 0;
          m_prod = 16'(req_a[8*g +: 8]) * 16'(req_b[8*g +: 8]);
          m_ptr  = (g + 1) % NREQ;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (rsp_ready[m_own]) begin
        m_have = 1'b0;
        m_count++;
      end
    end
  end

  task automatic edge_();
    acc_v = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic cyc();
    @(negedge clk);
    edge_();
  endtask

  // Leaves the bench at the negedge where req_ready[idx] is high.
  task automatic wait_grant(input int idx);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[idx]) return;
      edge_();
    end
    check("grant_timeout", 32'd0, 32'd1);
  endtask

  // Leaves the bench at the negedge where rsp_valid[idx] is high.
  task automatic wait_rsp(input int idx);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp_valid[idx]) return;
      edge_();
    end
    check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p);
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
    req_valid[idx]    = 1'b1;
    wait_grant(idx);
    edge_();
    req_valid[idx] = 1'b0;
    wait_rsp(idx);
    p = rsp_prod;
    edge_();
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  ra, rb;
    int          ri;
    bit          seen;

    // Reset with a request pending: nothing may be accepted.
    rst_n = 1'b0; req_valid = 4'b0001; req_a = '0; req_b = '0; rsp_ready = 4'hF;
    repeat (2) cyc();
    at_neg();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    check("rst_rsp_prod", 32'(rsp_prod), 32'h0);
    edge_();

    // Single op from requester 0.
    rst_n = 1'b1; req_a[7:0] = 8'h0C; req_b[7:0] = 8'h0A;
    at_neg();
    check("single_ready", 32'(req_ready), 32'h1);
    edge_();
    req_valid = 4'b0000;
    at_neg();
    check("single_mul_busy", 32'(busy), 32'h1);
    check("single_mul_rv", 32'(rsp_valid), 32'h0);
    edge_();
    at_neg();
    check("single_rv", 32'(rsp_valid), 32'h1);
    check("single_prod", 32'(rsp_prod), 32'h0078);
    edge_();
    at_neg();
    check("single_count", 32'(op_count), 32'h1);
    check("single_idle", 32'(busy), 32'h0);
    edge_();

    // Extremes.
    do_op(1, 8'hFF, 8'hFF, p);
    check("ext_ff_ff", 32'(p), 32'hFE01);
    do_op(2, 8'h00, 8'hFF, p);
    check("ext_00_ff", 32'(p), 32'h0000);

    // Round-robin: all requesters valid from reset.
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(i + 1);
      req_b[8*i +: 8] = 8'h10;
    end
    req_valid = 4'hF;
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        at_neg();
        if (rsp_valid != '0) seen = 1'b1;
        else edge_();
      end
      check("rr_seen", 32'(seen), 32'h1);
      check("rr_owner", 32'(rsp_valid), 32'(1 << (k % 4)));
      check("rr_prod", 32'(rsp_prod), 32'(16 * ((k % 4) + 1)));
      edge_();
    end
    req_valid = 4'h0;
    repeat (4) cyc();

    // Backpressure on requester 2 with another request waiting.
    rsp_ready = 4'b1011;
    req_a[23:16] = 8'h05; req_b[23:16] = 8'h07; req_valid = 4'b0100;
    wait_grant(2);
    edge_();
    req_a[7:0] = 8'h02; req_b[7:0] = 8'h03; req_valid = 4'b0001;
    wait_rsp(2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) at_neg();
      check("bp_rv", 32'(rsp_valid), 32'h4);
      check("bp_prod", 32'(rsp_prod), 32'h0023);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_busy", 32'(busy), 32'h1);
      edge_();
    end
    rsp_ready = 4'hF;
    at_neg();
    check("bp_hold_rv", 32'(rsp_valid), 32'h4);
    edge_();
    at_neg();
    check("bp_idle", 32'(busy), 32'h0);
    check("bp_next_grant", 32'(req_ready), 32'h1);
    edge_();
    req_valid = 4'h0;
    repeat (4) cyc();

    // Reset while the multiply is in progress.
    req_a[15:8] = 8'h09; req_b[15:8] = 8'h09; req_valid = 4'b0010;
    wait_grant(1);
    edge_();
    rst_n = 1'b0; req_valid = 4'h0;
    at_neg();
    check("midrst_busy_before", 32'(busy), 32'h1);
    edge_();
    rst_n = 1'b1;
    req_a[31:24] = 8'h11; req_b[31:24] = 8'h03; req_valid = 4'b1010;
    at_neg();
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_rv", 32'(rsp_valid), 32'h0);
    check("midrst_count", 32'(op_count), 32'h0);
    check("midrst_ptr0", 32'(req_ready), 32'h2);
    edge_();
    req_valid[1] = 1'b0;
    wait_rsp(1);
    check("midrst_prod1", 32'(rsp_prod), 32'h0051);
    edge_();
    wait_grant(3);
    edge_();
    req_valid = 4'h0;
    wait_rsp(3);
    check("midrst_prod3", 32'(rsp_prod), 32'h0033);
    edge_();
    at_neg();
    check("midrst_count2", 32'(op_count), 32'h2);
    edge_();

    // Counter wrap: 17 ops on a 4-bit counter.
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      ri = $urandom_range(0, NREQ - 1);
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ri, ra, rb, p);
      check("wrap_prod", 32'(p), 32'(16'(ra) * 16'(rb)));
    end
    at_neg();
    check("wrap_count", 32'(op_count), 32'h1);
    edge_();

    // Randomized traffic, backpressure, drops and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc_v[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_valid[i]    = 1'b1;
            req_a[8*i +: 8] = 8'($urandom);
            req_b[8*i +: 8] = 8'($urandom);
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    req_valid = 4'h0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
